// File: rtl/display_pkg.sv
// Shared types and helpers for the display page scheduler.
//   NUM_PAGES        : number of selectable display sources
//   page_t           : page index type
//   nibble_t         : one hex digit
//   next_valid_page  : rotating-priority search for the next valid page
package display_pkg;

  localparam int NUM_PAGES = 4;

  typedef logic [1:0] page_t;
  typedef logic [3:0] nibble_t;

  // Search starts at cur+1 and wraps 3->0. Walking the candidates from the
  // farthest to the nearest lets the nearest valid one win. If nothing other
  // than cur is valid, cur is returned unchanged.
  function automatic page_t next_valid_page(input page_t cur, input logic [3:0] valid);
    page_t cand;
    page_t result;
    result = cur;
    for (int i = NUM_PAGES - 1; i >= 1; i--) begin
      cand = cur + page_t'(i);
      if (valid[cand]) result = cand;
    end
    return result;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, debounce counter and a one-cycle
// pulse on the accepted rising edge.
//   clk, rst_n : system clock, async active-low reset
//   btn_raw    : raw asynchronous, bouncy button
//   press      : one-cycle pulse when the debounced level rises
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // The counter only runs while the synced input disagrees with the accepted
  // level; any return to the accepted level (a bounce) restarts the interval.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/display_page_scheduler.sv
// Selects which of four 16-bit datapath values is shown on the 4-digit
// 7-segment display. Pages advance on a debounced button press or an
// auto-rotate timer tick, skipping sources whose valid bit is clear.
//   clk, rst_n        : system clock, async active-low reset
//   btn_next          : raw page-advance button
//   auto_mode         : enable timer-driven rotation
//   freeze            : hold the displayed digits
//   src0..src3        : candidate display values
//   src_valid         : per-source valid bits
//   in3..in0          : hex digits of the selected value (in3 = MS nibble)
//   blank             : selected page has no valid source
//   page, page_led    : current page index and its one-hot
module display_page_scheduler
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_CYCLES     = 200_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        auto_mode,
  input  logic        freeze,
  input  logic [15:0] src0,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  input  logic [15:0] src3,
  input  logic [3:0]  src_valid,
  output logic [3:0]  in3,
  output logic [3:0]  in2,
  output logic [3:0]  in1,
  output logic [3:0]  in0,
  output logic        blank,
  output logic [1:0]  page,
  output logic [3:0]  page_led
);

  localparam int TIMER_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(AUTO_CYCLES - 1);

  logic               press;
  logic               tick;
  logic               advance;
  logic               load;
  logic [15:0]        sel_value;

  logic [TIMER_W-1:0] timer_q, timer_d;
  page_t              page_q, page_d;
  page_t              last_page_q, last_page_d;
  logic [15:0]        digits_q, digits_d;
  logic               blank_q, blank_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_next),
    .press  (press)
  );

  // Auto-rotate timer. A press restarts the interval so a manual advance
  // gets a full page time before the next automatic one.
  always_comb begin
    tick    = auto_mode && (timer_q == TIMER_LAST);
    timer_d = timer_q + 1'b1;
    if (!auto_mode || press || tick) timer_d = '0;
  end

  // A coincident press and tick collapse into a single advance.
  assign advance = press | tick;

  always_comb begin
    page_d      = page_q;
    last_page_d = page_q;
    if (advance) page_d = next_valid_page(page_q, src_valid);
  end

  always_comb begin
    sel_value = src0;
    unique case (page_q)
      2'd0: sel_value = src0;
      2'd1: sel_value = src1;
      2'd2: sel_value = src2;
      2'd3: sel_value = src3;
      default: sel_value = src0;
    endcase
  end

  // Under freeze the digits still load once after a page change (page_q no
  // longer matches last_page_q) and once when leaving blank, so the display
  // never sits on a stale page's value or on the zeros forced by blank.
  always_comb begin
    blank_d  = ~src_valid[page_q];
    load     = ~freeze | (page_q != last_page_q) | blank_q;
    digits_d = digits_q;
    if (blank_d)   digits_d = '0;
    else if (load) digits_d = sel_value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q     <= '0;
      page_q      <= '0;
      last_page_q <= '0;
      digits_q    <= '0;
      blank_q     <= 1'b1;
    end else begin
      timer_q     <= timer_d;
      page_q      <= page_d;
      last_page_q <= last_page_d;
      digits_q    <= digits_d;
      blank_q     <= blank_d;
    end
  end

  assign in3      = digits_q[15:12];
  assign in2      = digits_q[11:8];
  assign in1      = digits_q[7:4];
  assign in0      = digits_q[3:0];
  assign blank    = blank_q;
  assign page     = page_q;
  assign page_led = 4'b0001 << page_q;

endmodule

// File: tb/tb_display_page_scheduler.sv
module tb_display_page_scheduler;

  logic        clk;
  logic        rst_n;
  logic        btn_next;
  logic        auto_mode;
  logic        freeze;
  logic [15:0] src0, src1, src2, src3;
  logic [3:0]  src_valid;
  logic [3:0]  in3, in2, in1, in0;
  logic        blank;
  logic [1:0]  page;
  logic [3:0]  page_led;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [1:0]  exp_page;
    logic [3:0]  exp_led;
    logic        exp_blank;
    logic [15:0] exp_dig;
  } vec_t;

  vec_t vecs [9];

  display_page_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_CYCLES    (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_next (btn_next),
    .auto_mode(auto_mode),
    .freeze   (freeze),
    .src0     (src0),
    .src1     (src1),
    .src2     (src2),
    .src3     (src3),
    .src_valid(src_valid),
    .in3      (in3),
    .in2      (in2),
    .in1      (in1),
    .in0      (in0),
    .blank    (blank),
    .page     (page),
    .page_led (page_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {in3, in2, in1, in0};
  endfunction

  task automatic press_btn();
    btn_next = 1'b1;
    step(10);
    btn_next = 1'b0;
    step(10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_page"},  32'(page),     32'd0);
    check({tag, "_led"},   32'(page_led), 32'h1);
    check({tag, "_dig"},   32'(digits()), 32'h0);
    check({tag, "_blank"}, 32'(blank),    32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0001, 2'd0, 4'b0001, 1'b0, 16'h1234};
    vecs[1] = '{4'b1001, 2'd3, 4'b1000, 1'b0, 16'hDEF0};
    vecs[2] = '{4'b1001, 2'd0, 4'b0001, 1'b0, 16'h1234};
    vecs[3] = '{4'b0001, 2'd0, 4'b0001, 1'b0, 16'h1234};
    vecs[4] = '{4'b0000, 2'd0, 4'b0001, 1'b1, 16'h0000};
    vecs[5] = '{4'b0110, 2'd1, 4'b0010, 1'b0, 16'h5678};
    vecs[6] = '{4'b0101, 2'd2, 4'b0100, 1'b0, 16'h9ABC};
    vecs[7] = '{4'b0011, 2'd0, 4'b0001, 1'b0, 16'h1234};
    vecs[8] = '{4'b1111, 2'd1, 4'b0010, 1'b0, 16'h5678};

    rst_n     = 1'b0;
    btn_next  = 1'b0;
    auto_mode = 1'b0;
    freeze    = 1'b0;
    src0      = 16'h1234;
    src1      = 16'h5678;
    src2      = 16'h9ABC;
    src3      = 16'hDEF0;
    src_valid = 4'b1111;

    // Reset state, then first load after release.
    step(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step(1);
    check("post_reset_dig",   32'(digits()), 32'h1234);
    check("post_reset_blank", 32'(blank),    32'd0);

    // Bounce: HHLLHHLLHH, then held high -> single advance 0->1.
    for (int i = 0; i < 10; i++) begin
      btn_next = ((i / 2) % 2 == 0);
      step(1);
    end
    check("bounce_no_early_adv", 32'(page), 32'd0);
    step(8);
    check("bounce_one_adv", 32'(page), 32'd1);
    btn_next = 1'b0;
    step(10);
    check("bounce_release", 32'(page), 32'd1);

    // Skip / wrap / only-valid table, one press per entry.
    for (int i = 0; i < 9; i++) begin
      src_valid = vecs[i].valid;
      press_btn();
      check($sformatf("vec%0d_page", i),  32'(page),     32'(vecs[i].exp_page));
      check($sformatf("vec%0d_led", i),   32'(page_led), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d_blank", i), 32'(blank),    32'(vecs[i].exp_blank));
      check($sformatf("vec%0d_dig", i),   32'(digits()), 32'(vecs[i].exp_dig));
    end

    // Auto rotation from page 1, 16 cycles per page, with 3->0 wrap.
    auto_mode = 1'b1;
    step(15);
    check("auto_before_tick", 32'(page), 32'd1);
    step(1);
    check("auto_tick1", 32'(page), 32'd2);
    step(16);
    check("auto_tick2", 32'(page), 32'd3);
    step(16);
    check("auto_wrap", 32'(page), 32'd0);

    // Press landing on the same cycle as the tick: one advance, timer restarts.
    step(9);
    btn_next = 1'b1;
    step(6);
    check("collide_before", 32'(page), 32'd0);
    step(1);
    check("collide_single_adv", 32'(page), 32'd1);
    btn_next = 1'b0;
    step(15);
    check("collide_timer_restart", 32'(page), 32'd1);
    step(1);
    check("collide_next_tick", 32'(page), 32'd2);
    auto_mode = 1'b0;
    step(10);

    // Freeze: go to page 1, capture ABCD, then hold.
    src_valid = 4'b0010;
    press_btn();
    check("freeze_setup_page", 32'(page), 32'd1);
    src_valid = 4'b1111;
    src1 = 16'hABCD;
    step(1);
    check("freeze_load", 32'(digits()), 32'hABCD);
    freeze = 1'b1;
    src1 = 16'h0000;
    step(3);
    check("freeze_hold", 32'(digits()), 32'hABCD);
    src2 = 16'h5A5A;
    press_btn();
    check("freeze_page2", 32'(page), 32'd2);
    check("freeze_newpage_load", 32'(digits()), 32'h5A5A);
    src2 = 16'h1111;
    step(2);
    check("freeze_newpage_hold", 32'(digits()), 32'h5A5A);
    freeze = 1'b0;
    step(1);
    check("unfreeze_load", 32'(digits()), 32'h1111);

    // Invalidate current page: blank next cycle, digits 0, page stays.
    src_valid = 4'b1011;
    check("inval_blank_not_yet", 32'(blank), 32'd0);
    step(1);
    check("inval_blank", 32'(blank),    32'd1);
    check("inval_dig",   32'(digits()), 32'h0);
    check("inval_page",  32'(page),     32'd2);
    src_valid = 4'b1111;
    step(1);
    check("revalid_dig", 32'(digits()), 32'h1111);

    // Reset mid-debounce with the button held through release.
    btn_next = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step(2);
    rst_n = 1'b1;
    step(5);
    check("held_btn_not_yet", 32'(page), 32'd0);
    step(5);
    check("held_btn_press", 32'(page), 32'd1);
    step(10);
    check("held_btn_single", 32'(page), 32'd1);
    btn_next = 1'b0;
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
